// File: rtl/rf_sb_pkg.sv
// Shared types for the register-file scoreboard and write-port arbiter.
package rf_sb_pkg;

    localparam int NREGS = 32;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/rf_scoreboard_arb_if.sv
// Issue, writeback and register-file port bundle of rf_scoreboard_arb.
interface rf_scoreboard_arb_if #(
    parameter int XLEN = 32
);
    import rf_sb_pkg::*;

    logic            flush_i;
    logic            issue_valid_i;
    logic            issue_ready_o;
    logic            issue_we_i;
    reg_idx_t        issue_rd_i;
    reg_idx_t        issue_rs1_i;
    reg_idx_t        issue_rs2_i;
    logic            alu_wb_valid_i;
    logic            alu_wb_ready_o;
    reg_idx_t        alu_wb_rd_i;
    logic [XLEN-1:0] alu_wb_data_i;
    logic            lsu_wb_valid_i;
    logic            lsu_wb_ready_o;
    reg_idx_t        lsu_wb_rd_i;
    logic [XLEN-1:0] lsu_wb_data_i;
    reg_idx_t        rf_rd_o;
    logic [XLEN-1:0] rf_data_o;
    logic            busy_o;

    modport slave (
        input  flush_i, issue_valid_i, issue_we_i, issue_rd_i, issue_rs1_i, issue_rs2_i,
        input  alu_wb_valid_i, alu_wb_rd_i, alu_wb_data_i,
        input  lsu_wb_valid_i, lsu_wb_rd_i, lsu_wb_data_i,
        output issue_ready_o, alu_wb_ready_o, lsu_wb_ready_o, rf_rd_o, rf_data_o, busy_o
    );

    modport master (
        output flush_i, issue_valid_i, issue_we_i, issue_rd_i, issue_rs1_i, issue_rs2_i,
        output alu_wb_valid_i, alu_wb_rd_i, alu_wb_data_i,
        output lsu_wb_valid_i, lsu_wb_rd_i, lsu_wb_data_i,
        input  issue_ready_o, alu_wb_ready_o, lsu_wb_ready_o, rf_rd_o, rf_data_o, busy_o
    );

endinterface

// File: rtl/rf_wb_rr_arb.sv
// Two-way round-robin arbiter between ALU and LSU writebacks.
module rf_wb_rr_arb
    import rf_sb_pkg::*;
(
    input  logic    clk,
    input  logic    rst_i,
    input  logic    alu_valid_i,
    input  logic    lsu_valid_i,
    output logic    alu_grant_o,
    output logic    lsu_grant_o,
    output wb_src_e sel_o
);

    wb_src_e last_grant_q;
    wb_src_e last_grant_d;

    // Grants are suppressed while reset is held so nothing is accepted or written.
    always_comb begin
        alu_grant_o  = 1'b0;
        lsu_grant_o  = 1'b0;
        last_grant_d = last_grant_q;
        if (!rst_i) begin
            if (alu_valid_i && lsu_valid_i) begin
                if (last_grant_q == WB_LSU) alu_grant_o = 1'b1;
                else                        lsu_grant_o = 1'b1;
            end else begin
                alu_grant_o = alu_valid_i;
                lsu_grant_o = lsu_valid_i;
            end
        end
        sel_o = lsu_grant_o ? WB_LSU : WB_ALU;
        if (alu_grant_o || lsu_grant_o) last_grant_d = sel_o;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) last_grant_q <= WB_LSU;
        else       last_grant_q <= last_grant_d;
    end

endmodule

// File: rtl/rf_scoreboard_arb.sv
// Hazard scoreboard plus writeback arbitration for the single-write-port register file.
// Define RF_SB_OUTREG_EN to register rf_rd_o/rf_data_o (one extra cycle of write latency).
module rf_scoreboard_arb #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic clk,
    input  logic rst_i,
    rf_scoreboard_arb_if.slave bus
);
    import rf_sb_pkg::*;

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic             alu_grant;
    logic             lsu_grant;
    wb_src_e          sel;
    reg_idx_t         wb_rd;
    logic [XLEN-1:0]  wb_data;
    reg_idx_t         commit_rd;
    logic             hazard;
    logic             issue_fire;

    rf_wb_rr_arb u_arb (
        .clk         (clk),
        .rst_i       (rst_i),
        .alu_valid_i (bus.alu_wb_valid_i),
        .lsu_valid_i (bus.lsu_wb_valid_i),
        .alu_grant_o (alu_grant),
        .lsu_grant_o (lsu_grant),
        .sel_o       (sel)
    );

    assign bus.alu_wb_ready_o = alu_grant;
    assign bus.lsu_wb_ready_o = lsu_grant;

    always_comb begin
        wb_rd   = '0;
        wb_data = '0;
        if (alu_grant || lsu_grant) begin
            wb_rd   = (sel == WB_ALU) ? bus.alu_wb_rd_i   : bus.lsu_wb_rd_i;
            wb_data = (sel == WB_ALU) ? bus.alu_wb_data_i : bus.lsu_wb_data_i;
        end
    end

`ifdef RF_SB_OUTREG_EN
    reg_idx_t        rf_rd_q;
    logic [XLEN-1:0] rf_data_q;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            rf_rd_q   <= '0;
            rf_data_q <= '0;
        end else begin
            rf_rd_q   <= wb_rd;
            rf_data_q <= wb_data;
        end
    end

    // The register file commits what it sees on the port, so that is what retires a pending bit.
    assign bus.rf_rd_o   = rf_rd_q;
    assign bus.rf_data_o = rf_data_q;
    assign commit_rd     = rf_rd_q;
`else
    assign bus.rf_rd_o   = wb_rd;
    assign bus.rf_data_o = wb_data;
    assign commit_rd     = wb_rd;
`endif

    always_comb begin
        hazard = pending_q[bus.issue_rs1_i] | pending_q[bus.issue_rs2_i] |
                 (bus.issue_we_i & pending_q[bus.issue_rd_i]);
        issue_fire = bus.issue_valid_i & ~hazard;
    end

    assign bus.issue_ready_o = ~hazard;
    assign bus.busy_o        = |pending_q;

    // Order matters: commit clears, a new issue to the same register re-sets, flush clears all.
    always_comb begin
        pending_d            = pending_q;
        pending_d[commit_rd] = 1'b0;
        if (issue_fire && bus.issue_we_i && (bus.issue_rd_i != '0))
            pending_d[bus.issue_rd_i] = 1'b1;
        if (bus.flush_i)
            pending_d = '0;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) pending_q <= '0;
        else       pending_q <= pending_d;
    end

endmodule

// File: tb/tb_rf_scoreboard_arb.sv
// Directed bench for rf_scoreboard_arb; adapts latency checks when RF_SB_OUTREG_EN is defined.
module tb_rf_scoreboard_arb;
    import rf_sb_pkg::*;

`ifdef RF_SB_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic alu_v;
        logic lsu_v;
        logic exp_alu_rdy;
        logic exp_lsu_rdy;
        logic exp_issue_rdy;
    } arb_vec_t;

    logic clk   = 1'b0;
    logic rst_i = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [31:0] rf_model [32];
    logic [4:0]  log_rd [$];
    logic [31:0] log_data [$];

    always #5 clk = ~clk;

    rf_scoreboard_arb_if #(.XLEN(32)) bus ();

    rf_scoreboard_arb #(.NREGS(32), .XLEN(32)) dut (
        .clk   (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // Behavioural register file: records every committed write.
    always @(posedge clk) begin
        if (bus.rf_rd_o != 5'd0) begin
            rf_model[bus.rf_rd_o] <= bus.rf_data_o;
            log_rd.push_back(bus.rf_rd_o);
            log_data.push_back(bus.rf_data_o);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.flush_i        = 1'b0;
        bus.issue_valid_i  = 1'b0;
        bus.issue_we_i     = 1'b0;
        bus.issue_rd_i     = '0;
        bus.issue_rs1_i    = '0;
        bus.issue_rs2_i    = '0;
        bus.alu_wb_valid_i = 1'b0;
        bus.alu_wb_rd_i    = '0;
        bus.alu_wb_data_i  = '0;
        bus.lsu_wb_valid_i = 1'b0;
        bus.lsu_wb_rd_i    = '0;
        bus.lsu_wb_data_i  = '0;
    endtask

    task automatic drive_issue(input logic valid, input logic we, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2);
        bus.issue_valid_i = valid;
        bus.issue_we_i    = we;
        bus.issue_rd_i    = rd;
        bus.issue_rs1_i   = rs1;
        bus.issue_rs2_i   = rs2;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        arb_vec_t vecs [9];
        logic [4:0]  exp_rd   [8];
        logic [31:0] exp_data [8];
        int k_ready;
        int log_len;

        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_rd   = '{5'd3, 5'd4, 5'd3, 5'd4, 5'd4, 5'd3, 5'd3, 5'd4};
        exp_data = '{32'h11, 32'h22, 32'h11, 32'h22, 32'h22, 32'h11, 32'h11, 32'h22};

        for (int i = 0; i < 32; i++) rf_model[i] = '0;
        idle_inputs();
        bus.alu_wb_rd_i   = 5'd3;
        bus.alu_wb_data_i = 32'h11;
        bus.lsu_wb_rd_i   = 5'd4;
        bus.lsu_wb_data_i = 32'h22;
        bus.alu_wb_valid_i = 1'b1;
        bus.lsu_wb_valid_i = 1'b1;

        // Reset held with traffic present: nothing granted, nothing written.
        @(negedge clk);
        #1;
        check("rst_issue_ready", bus.issue_ready_o, 1'b1);
        check("rst_busy", bus.busy_o, 1'b0);
        check("rst_rf_rd", bus.rf_rd_o, 5'd0);
        check("rst_alu_ready", bus.alu_wb_ready_o, 1'b0);
        check("rst_lsu_ready", bus.lsu_wb_ready_o, 1'b0);
        @(negedge clk);
        rst_i = 1'b0;

        // Contention table from reset: first tie goes to ALU, then alternates.
        for (int i = 0; i < 9; i++) begin
            bus.alu_wb_valid_i = vecs[i].alu_v;
            bus.lsu_wb_valid_i = vecs[i].lsu_v;
            #1;
            check($sformatf("arb%0d_alu_ready", i), bus.alu_wb_ready_o, vecs[i].exp_alu_rdy);
            check($sformatf("arb%0d_lsu_ready", i), bus.lsu_wb_ready_o, vecs[i].exp_lsu_rdy);
            check($sformatf("arb%0d_issue_ready", i), bus.issue_ready_o, vecs[i].exp_issue_rdy);
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        check("arb_write_count", log_rd.size(), 8);
        for (int i = 0; i < 8 && i < log_rd.size(); i++) begin
            check($sformatf("arb_write%0d_rd", i), log_rd[i], exp_rd[i]);
            check($sformatf("arb_write%0d_data", i), log_data[i], exp_data[i]);
        end

        // RAW: x5 pending, dependent issue stalls until the ALU write commits.
        drive_issue(1'b1, 1'b1, 5'd5, 5'd0, 5'd0);
        #1;
        check("raw_producer_ready", bus.issue_ready_o, 1'b1);
        @(negedge clk);
        drive_issue(1'b1, 1'b0, 5'd0, 5'd5, 5'd0);
        bus.alu_wb_valid_i = 1'b1;
        bus.alu_wb_rd_i    = 5'd5;
        bus.alu_wb_data_i  = 32'hDEADBEEF;
        #1;
        check("raw_stall", bus.issue_ready_o, 1'b0);
        check("raw_busy", bus.busy_o, 1'b1);
        check("raw_alu_ready", bus.alu_wb_ready_o, 1'b1);
        @(negedge clk);
        bus.alu_wb_valid_i = 1'b0;
        k_ready = 0;
        for (int k = 1; k <= 4 && k_ready == 0; k++) begin
            #1;
            if (bus.issue_ready_o) k_ready = k;
            else @(negedge clk);
        end
        check("raw_release_latency", k_ready, LAT);
        @(negedge clk);
        idle_inputs();
        #1;
        check("raw_rf_value", rf_model[5], 32'hDEADBEEF);
        check("raw_busy_clear", bus.busy_o, 1'b0);
        @(negedge clk);

        // x0: issue to rd=0 sets nothing; ALU writeback to rd=0 is accepted but not written.
        drive_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
        #1;
        check("x0_issue_ready", bus.issue_ready_o, 1'b1);
        @(negedge clk);
        idle_inputs();
        bus.alu_wb_valid_i = 1'b1;
        bus.alu_wb_rd_i    = 5'd0;
        bus.alu_wb_data_i  = 32'h55;
        #1;
        check("x0_no_pending", bus.busy_o, 1'b0);
        check("x0_alu_ready", bus.alu_wb_ready_o, 1'b1);
        check("x0_rf_rd_now", bus.rf_rd_o, 5'd0);
        @(negedge clk);
        bus.alu_wb_valid_i = 1'b0;
        #1;
        check("x0_rf_rd_next", bus.rf_rd_o, 5'd0);
        @(negedge clk);

        // WAW on x7, flush clears it, a late LSU write to x7 still lands.
        drive_issue(1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
        #1;
        check("waw_first_ready", bus.issue_ready_o, 1'b1);
        @(negedge clk);
        #1;
        check("waw_stall", bus.issue_ready_o, 1'b0);
        check("waw_busy", bus.busy_o, 1'b1);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i       = 1'b0;
        bus.issue_valid_i = 1'b0;
        bus.lsu_wb_valid_i = 1'b1;
        bus.lsu_wb_rd_i    = 5'd7;
        bus.lsu_wb_data_i  = 32'h77;
        #1;
        check("flush_issue_ready", bus.issue_ready_o, 1'b1);
        check("flush_busy", bus.busy_o, 1'b0);
        check("flush_lsu_ready", bus.lsu_wb_ready_o, 1'b1);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        #1;
        check("flush_late_busy", bus.busy_o, 1'b0);
        check("flush_late_rf", rf_model[7], 32'h77);
        @(negedge clk);

        // Commit of x9 on the same edge as a new issue to x9: the set survives.
`ifdef RF_SB_OUTREG_EN
        bus.alu_wb_valid_i = 1'b1;
        bus.alu_wb_rd_i    = 5'd9;
        bus.alu_wb_data_i  = 32'h99;
        #1;
        check("coll_alu_ready", bus.alu_wb_ready_o, 1'b1);
        @(negedge clk);
        bus.alu_wb_valid_i = 1'b0;
`else
        bus.alu_wb_valid_i = 1'b1;
        bus.alu_wb_rd_i    = 5'd9;
        bus.alu_wb_data_i  = 32'h99;
`endif
        drive_issue(1'b1, 1'b1, 5'd9, 5'd0, 5'd0);
        #1;
        check("coll_issue_ready", bus.issue_ready_o, 1'b1);
        check("coll_rf_rd", bus.rf_rd_o, 5'd9);
        @(negedge clk);
        idle_inputs();
        bus.issue_rs1_i = 5'd9;
        #1;
        check("coll_busy", bus.busy_o, 1'b1);
        check("coll_dep_stall", bus.issue_ready_o, 1'b0);

        // Asynchronous reset in the middle of traffic with x9 still pending.
        @(negedge clk);
        bus.alu_wb_valid_i = 1'b1;
        bus.alu_wb_rd_i    = 5'd12;
        bus.alu_wb_data_i  = 32'hAB;
        bus.lsu_wb_valid_i = 1'b1;
        bus.lsu_wb_rd_i    = 5'd13;
        bus.lsu_wb_data_i  = 32'hCD;
        #1;
        check("mid_busy_before", bus.busy_o, 1'b1);
        rst_i = 1'b1;
        #1;
        check("mid_rst_issue_ready", bus.issue_ready_o, 1'b1);
        check("mid_rst_busy", bus.busy_o, 1'b0);
        check("mid_rst_rf_rd", bus.rf_rd_o, 5'd0);
        check("mid_rst_alu_ready", bus.alu_wb_ready_o, 1'b0);
        log_len = log_rd.size();
        @(negedge clk);
        idle_inputs();
        rst_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mid_rst_no_write", log_rd.size(), log_len);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
